// File: rtl/img_rx_if.sv
// Byte-in / bit-out bundle between the UART receiver, the image unpacker and the
// input-image RAM / core controller.
interface img_rx_if #(
    parameter int ADDR_W = 10
);
    logic              rx_rdy;
    logic [7:0]        rx_data;
    logic              img_ack;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic              wdata;
    logic              img_rdy;
    logic              ovr;
    logic              busy;

    modport master (
        output rx_rdy, rx_data, img_ack,
        input  we, waddr, wdata, img_rdy, ovr, busy
    );

    modport slave (
        input  rx_rdy, rx_data, img_ack,
        output we, waddr, wdata, img_rdy, ovr, busy
    );
endinterface

// File: rtl/img_rx_unpack.sv
// Unpacks received bytes LSB-first into single-bit RAM writes and flags a
// complete image until the core acknowledges it.
//
// state | meaning
// IDLE  | waiting for the next byte of the current image
// WRITE | emitting the 8 bit writes of the latched byte
// DONE  | image complete, img_rdy held until img_ack
module img_rx_unpack #(
    parameter int NUM_BITS = 784,
    parameter int ADDR_W   = 10
) (
    input logic        clk,
    input logic        rst_n,
    img_rx_if.slave    bus
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] WRITE = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(NUM_BITS - 8);
    localparam logic [ADDR_W-1:0] STEP     = ADDR_W'(8);

    logic [1:0]        state;
    logic [ADDR_W-1:0] ptr;
    logic [2:0]        idx;
    logic [7:0]        sr;
    logic              accept;
    logic              drop;

    // An ack arriving alongside a byte lets that byte open the next image.
    assign accept = bus.rx_rdy && ((state == IDLE) || (state == DONE && bus.img_ack));
    assign drop   = bus.rx_rdy && !accept;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            ptr         <= '0;
            idx         <= '0;
            sr          <= '0;
            bus.we      <= 1'b0;
            bus.waddr   <= '0;
            bus.wdata   <= 1'b0;
            bus.img_rdy <= 1'b0;
            bus.ovr     <= 1'b0;
            bus.busy    <= 1'b0;
        end else begin
            if (accept) begin
                sr        <= bus.rx_data;
                bus.we    <= 1'b1;
                bus.waddr <= ptr;
                bus.wdata <= bus.rx_data[0];
                bus.busy  <= 1'b1;
                idx       <= 3'd1;
                state     <= WRITE;
            end else begin
                case (state)
                    IDLE: ;
                    WRITE: begin
                        // idx wraps to 0 once bit 7 has been issued
                        if (idx == 3'd0) begin
                            bus.we   <= 1'b0;
                            bus.busy <= 1'b0;
                            if (ptr == LAST_PTR) begin
                                ptr         <= '0;
                                bus.img_rdy <= 1'b1;
                                state       <= DONE;
                            end else begin
                                ptr   <= ptr + STEP;
                                state <= IDLE;
                            end
                        end else begin
                            bus.waddr <= ptr + ADDR_W'(idx);
                            bus.wdata <= sr[idx];
                            idx       <= idx + 3'd1;
                        end
                    end
                    DONE: begin
                        if (bus.img_ack) state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end

            if (state == DONE && bus.img_ack) begin
                bus.img_rdy <= 1'b0;
                bus.ovr     <= 1'b0;
            end else if (drop) begin
                bus.ovr <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_img_rx_unpack.sv
// Directed sequence with random bytes/spacing; a bit-addressed RAM model filled
// from observed writes is compared against the expected image bytes.
module tb_img_rx_unpack;
    localparam int NUM_BITS = 784;
    localparam int ADDR_W   = 10;
    localparam int NBYTES   = NUM_BITS / 8;

    logic clk = 1'b0;
    logic rst_n;

    img_rx_if #(.ADDR_W(ADDR_W)) bus ();

    img_rx_unpack #(.NUM_BITS(NUM_BITS), .ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #10 clk = ~clk;

    int   total = 0;
    int   passed = 0;
    int   gen = 0;
    int   base = 0;
    logic [7:0] img [NBYTES];

    // RAM model: a bit is valid only if written during the current generation
    logic ram     [1 << ADDR_W];
    int   ram_gen [1 << ADDR_W];
    int   wr_total = 0;
    int   last_addr = -1;

    always @(negedge clk) begin
        if (bus.we) begin
            ram[bus.waddr]     <= bus.wdata;
            ram_gen[bus.waddr] <= gen;
            wr_total           <= wr_total + 1;
            last_addr          <= int'(bus.waddr);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [7:0] b, input logic ack);
        bus.rx_rdy  = 1'b1;
        bus.rx_data = b;
        bus.img_ack = ack;
        tick();
        bus.rx_rdy  = 1'b0;
        bus.img_ack = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("reset_outs", 32'({bus.we, bus.waddr, bus.wdata, bus.img_rdy, bus.ovr, bus.busy}), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic new_image();
        gen++;
        base = wr_total;
    endtask

    task automatic check_bits(input string tag, input int lo, input int hi);
        int bad = 0;
        for (int i = lo; i <= hi; i++)
            if (ram_gen[i] != gen || ram[i] !== img[i / 8][i % 8]) bad++;
        chk(tag, 32'(bad), 32'd0);
    endtask

    // Sends bytes first..NBYTES-1 with random legal spacing, then times img_rdy.
    task automatic feed(input int first, input string tag);
        int n;
        for (int i = first; i < NBYTES; i++) begin
            repeat (8 + $urandom_range(0, 10)) tick();
            chk({tag, "_rdy_low"}, 32'(bus.img_rdy), 32'd0);
            img[i] = 8'($urandom);
            pulse(img[i], 1'b0);
        end
        n = 1;
        while (!bus.img_rdy && n < 40) begin
            tick();
            n++;
        end
        chk({tag, "_latency"}, 32'(n), 32'd9);
        chk({tag, "_we_done"}, 32'(bus.we), 32'd0);
        chk({tag, "_last_addr"}, 32'(last_addr), 32'(NUM_BITS - 1));
        chk({tag, "_wr_count"}, 32'(wr_total - base), 32'(NUM_BITS));
        check_bits({tag, "_bits"}, 0, NUM_BITS - 1);
    endtask

    initial begin
        logic [7:0] b;
        bus.rx_rdy  = 1'b0;
        bus.rx_data = 8'h00;
        bus.img_ack = 1'b0;
        rst_n       = 1'b1;
        #3;

        // single byte after reset
        do_reset();
        b = 8'hA5;
        pulse(b, 1'b0);
        for (int k = 0; k < 8; k++) begin
            chk("a5_we", 32'(bus.we), 32'd1);
            chk("a5_waddr", 32'(bus.waddr), 32'(k));
            chk("a5_wdata", 32'(bus.wdata), 32'((8'hA5 >> k) & 8'h1));
            chk("a5_busy", 32'(bus.busy), 32'd1);
            tick();
        end
        chk("a5_end", 32'({bus.we, bus.busy, bus.img_rdy}), 32'd0);

        // overrun during WRITE
        do_reset();
        new_image();
        img[0] = 8'($urandom);
        img[1] = 8'($urandom);
        pulse(img[0], 1'b0);
        tick();
        tick();
        pulse(8'($urandom), 1'b0);
        repeat (10) tick();
        chk("ovr_set", 32'(bus.ovr), 32'd1);
        chk("ovr_count1", 32'(wr_total - base), 32'd8);
        check_bits("ovr_byte0", 0, 7);
        pulse(img[1], 1'b0);
        chk("ovr_next_addr", 32'(bus.waddr), 32'd8);
        repeat (10) tick();
        chk("ovr_count2", 32'(wr_total - base), 32'd16);
        check_bits("ovr_byte1", 8, 15);
        chk("ovr_sticky", 32'(bus.ovr), 32'd1);

        // full image, then drop in DONE, then ack
        do_reset();
        new_image();
        feed(0, "img1");
        base = wr_total;
        pulse(8'hFF, 1'b0);
        chk("done_drop_we", 32'(bus.we), 32'd0);
        chk("done_drop_ovr", 32'(bus.ovr), 32'd1);
        chk("done_drop_rdy", 32'(bus.img_rdy), 32'd1);
        repeat (10) tick();
        chk("done_drop_nowr", 32'(wr_total - base), 32'd0);
        chk("done_rdy_held", 32'(bus.img_rdy), 32'd1);
        bus.img_ack = 1'b1;
        tick();
        bus.img_ack = 1'b0;
        chk("ack_rdy", 32'(bus.img_rdy), 32'd0);
        chk("ack_ovr", 32'(bus.ovr), 32'd0);
        tick();
        pulse(8'($urandom), 1'b0);
        chk("after_ack_we", 32'(bus.we), 32'd1);
        chk("after_ack_addr", 32'(bus.waddr), 32'd0);

        // reset in the middle of byte 50's write
        new_image();
        for (int i = 1; i < 50; i++) begin
            repeat (8 + $urandom_range(0, 4)) tick();
            pulse(8'($urandom), 1'b0);
        end
        repeat (9) tick();
        pulse(8'($urandom), 1'b0);
        tick();
        tick();
        chk("mid_busy", 32'(bus.busy), 32'd1);
        do_reset();
        new_image();
        feed(0, "img2");

        // byte and ack together in DONE
        new_image();
        img[0] = 8'h3C;
        pulse(8'h3C, 1'b1);
        chk("combo_rdy", 32'(bus.img_rdy), 32'd0);
        chk("combo_we", 32'(bus.we), 32'd1);
        chk("combo_addr", 32'(bus.waddr), 32'd0);
        chk("combo_data", 32'(bus.wdata), 32'd0);
        feed(1, "img3");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end
endmodule
